imm_extend_stage: RTL and testbench

//  Registered immediate-generation stage between decode and execute. Accepts instr[31:7], an imm_src

---
 rtl/rvscc_pkg.sv | 29 ++
 rtl/imm_extend_stage_if.sv | 35 +++
 rtl/imm_extend_stage_comb.sv | 38 +++
 rtl/imm_extend_stage.sv | 103 ++++++++++
 tb/tb_imm_extend_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/rvscc_pkg.sv
// ============================================================================
// Module : rvscc_pkg
// Brief  : Shared immediate-format selector and stage entry layout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rvscc_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_extend_stage_if.sv
// ============================================================================
// Module : imm_extend_stage_if
// Brief  : Input/output handshake bundle of the immediate-extend stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imm_extend_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     in_instr;
  logic [2:0]      in_imm_src;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm_ext;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_imm_src, in_pc, out_ready,
    input  in_ready, out_valid, out_imm_ext, out_target, out_pc, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_imm_src, in_pc, out_ready,
    output in_ready, out_valid, out_imm_ext, out_target, out_pc, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/imm_extend_stage_comb.sv
// ============================================================================
// Module : imm_extend_comb
// Brief  : Combinational RISC-V immediate decode, sign-extended to XLEN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_extend_comb
  import rvscc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [24:0]     i_instr,
  input  wire logic [2:0]      i_imm_src,
  output      logic [XLEN-1:0] o_imm,
  output      logic            o_illegal
);

  // i_instr[k] carries instruction bit k+7
  logic w_s;
  assign w_s = i_instr[24];

  always_comb begin
    o_imm     = '0;
    o_illegal = 1'b0;
    case (i_imm_src)
      IMM_I:   o_imm = {{(XLEN-11){w_s}}, i_instr[23:13]};
      IMM_S:   o_imm = {{(XLEN-11){w_s}}, i_instr[23:18], i_instr[4:0]};
      IMM_B:   o_imm = {{(XLEN-12){w_s}}, i_instr[0], i_instr[23:18], i_instr[4:1], 1'b0};
      IMM_J:   o_imm = {{(XLEN-20){w_s}}, i_instr[12:5], i_instr[13], i_instr[23:14], 1'b0};
      IMM_U:   o_imm = {{(XLEN-31){w_s}}, i_instr[23:5], 12'b0};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_extend_stage.sv
// ============================================================================
// Module : imm_extend_stage
// Brief  : Registered immediate-generation stage with 2-entry skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_extend_stage
  import rvscc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input wire logic          clk,
  input wire logic          rstn,
  imm_extend_stage_if.slave bus
);

  generate
    if (SKID_DEPTH != 2) begin : g_depth_check
      $error("imm_extend_stage: SKID_DEPTH must be 2");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } stage_entry_t;

  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  stage_entry_t    w_new;
  stage_entry_t    r_e0;
  stage_entry_t    r_e1;
  logic [1:0]      r_count;
  logic [1:0]      w_count_nxt;
  logic            r_in_ready;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_e0;

  imm_extend_comb #(.XLEN(XLEN)) u_comb (
    .i_instr   (bus.in_instr),
    .i_imm_src (bus.in_imm_src),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  // Illegal formats decode to imm=0, so the target collapses to pc.
  always_comb begin
    w_new.imm     = w_imm;
    w_new.target  = bus.in_pc + w_imm;
    w_new.pc      = bus.in_pc;
    w_new.illegal = w_illegal;
  end

  always_comb begin
    w_in_fire  = bus.in_valid & r_in_ready;
    w_out_fire = (r_count != 2'd0) & bus.out_ready;
    w_load_e0  = (r_count == 2'd0) | ((r_count == 2'd1) & w_out_fire);
    if (bus.flush) begin
      w_count_nxt = 2'd0;
    end else begin
      w_count_nxt = r_count + {1'b0, w_in_fire} - {1'b0, w_out_fire};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_e0       <= '0;
      r_e1       <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      if (!bus.flush) begin
        if (w_out_fire && (r_count == 2'd2)) begin
          r_e0 <= r_e1;
        end
        if (w_in_fire) begin
          if (w_load_e0) begin
            r_e0 <= w_new;
          end else begin
            r_e1 <= w_new;
          end
        end
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = (r_count != 2'd0);
  assign bus.out_imm_ext = r_e0.imm;
  assign bus.out_target  = r_e0.target;
  assign bus.out_pc      = r_e0.pc;
  assign bus.out_illegal = r_e0.illegal;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
// ============================================================================
// Module : tb_imm_extend_stage
// Brief  : Directed self-checking bench for imm_extend_stage (XLEN 32 and 64).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_stage;

  logic clk;
  logic rstn;

  imm_extend_stage_if #(.XLEN(32)) bus32 ();
  imm_extend_stage_if #(.XLEN(64)) bus64 ();

  imm_extend_stage #(.XLEN(32), .SKID_DEPTH(2)) dut32 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus32)
  );

  imm_extend_stage #(.XLEN(64), .SKID_DEPTH(2)) dut64 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] pc);
    bus32.in_valid   = v;
    bus32.in_instr   = ins[31:7];
    bus32.in_imm_src = src;
    bus32.in_pc      = pc;
  endtask

  logic [31:0] vec_instr [6] = '{32'h00100093, 32'hFFF00093, 32'hFE112C23,
                                 32'h00000463, 32'hFFDFF06F, 32'h123450B7};
  logic [2:0]  vec_src   [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] vec_imm   [6] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFF8,
                                 32'h00000008, 32'hFFFFFFFC, 32'h12345000};
  logic [31:0] vec_tgt   [6] = '{32'h00000101, 32'h000000FF, 32'h000000F8,
                                 32'h00000108, 32'h000000FC, 32'h12345100};

  initial begin
    rstn = 1'b0;
    bus32.flush = 1'b0; bus32.out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    bus64.flush = 1'b0; bus64.out_ready = 1'b1; bus64.in_valid = 1'b0;
    bus64.in_instr = '0; bus64.in_imm_src = 3'd0; bus64.in_pc = '0;
    step(); step();
    rstn = 1'b1;
    chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    chk("rst_imm",       64'(bus32.out_imm_ext), 64'd0);

    // Format decode with a free-running sink
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vec_instr[i], vec_src[i], 32'h100);
      step();
      drive(1'b0, 32'h0, 3'd0, 32'h0);
      chk($sformatf("fmt%0d_valid", i),  64'(bus32.out_valid),   64'd1);
      chk($sformatf("fmt%0d_imm", i),    64'(bus32.out_imm_ext), 64'(vec_imm[i]));
      chk($sformatf("fmt%0d_target", i), 64'(bus32.out_target),  64'(vec_tgt[i]));
      chk($sformatf("fmt%0d_illegal", i), 64'(bus32.out_illegal), 64'd0);
      step();
    end

    // Illegal selector, then a back-to-back legal entry clears the flag
    drive(1'b1, 32'h00100093, 3'd6, 32'h200);
    step();
    chk("ill_flag",   64'(bus32.out_illegal), 64'd1);
    chk("ill_imm",    64'(bus32.out_imm_ext), 64'd0);
    chk("ill_target", 64'(bus32.out_target),  64'h200);
    drive(1'b1, 32'h00100093, 3'd0, 32'h200);
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    chk("ill_clear",     64'(bus32.out_illegal), 64'd0);
    chk("ill_next_imm",  64'(bus32.out_imm_ext), 64'd1);
    chk("ill_next_valid", 64'(bus32.out_valid),  64'd1);
    step();
    chk("ill_drained", 64'(bus32.out_valid), 64'd0);

    // Target wraps at 2^32; a 64-bit U immediate sign-extends
    drive(1'b1, 32'h00000463, 3'd2, 32'hFFFFFFFC);
    bus64.in_valid = 1'b1; bus64.in_instr = 25'(32'h80000037 >> 7); bus64.in_imm_src = 3'd4;
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    bus64.in_valid = 1'b0;
    chk("wrap_target", 64'(bus32.out_target), 64'h4);
    chk("x64_u_imm",    bus64.out_imm_ext, 64'hFFFFFFFF80000000);
    chk("x64_u_target", bus64.out_target,  64'hFFFFFFFF80000000);
    step();

    // Backpressure: three pushes, only two accepted
    bus32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 32'h10);
    step();
    chk("bp_rdy1",  64'(bus32.in_ready),  64'd1);
    chk("bp_pc1",   64'(bus32.out_pc),    64'h10);
    drive(1'b1, 32'hFFF00093, 3'd0, 32'h20);
    step();
    chk("bp_rdy2",  64'(bus32.in_ready),  64'd0);
    drive(1'b1, 32'hFE112C23, 3'd1, 32'h30);
    step();
    chk("bp_rdy3",   64'(bus32.in_ready),    64'd0);
    chk("bp_stable", 64'(bus32.out_pc),      64'h10);
    chk("bp_imm1",   64'(bus32.out_imm_ext), 64'd1);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    bus32.out_ready = 1'b1;
    step();
    chk("bp_pc2",    64'(bus32.out_pc),      64'h20);
    chk("bp_imm2",   64'(bus32.out_imm_ext), 64'hFFFFFFFF);
    chk("bp_rdy_up", 64'(bus32.in_ready),    64'd1);
    step();
    chk("bp_empty",  64'(bus32.out_valid),   64'd0);

    // Flush with count=2 and a concurrent input attempt
    bus32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 32'h40); step();
    drive(1'b1, 32'h00100093, 3'd0, 32'h50); step();
    drive(1'b1, 32'h00100093, 3'd0, 32'h60);
    bus32.flush = 1'b1; bus32.out_ready = 1'b1;
    step();
    bus32.flush = 1'b0;
    chk("fl2_valid", 64'(bus32.out_valid), 64'd0);
    chk("fl2_rdy",   64'(bus32.in_ready),  64'd1);
    // Flush with count=1 while an input really fires: that input is dropped
    bus32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 32'h70); step();
    drive(1'b1, 32'h00100093, 3'd0, 32'h80);
    bus32.flush = 1'b1;
    step();
    bus32.flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    bus32.out_ready = 1'b1;
    chk("fl1_valid", 64'(bus32.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), 64'(bus32.out_valid), 64'd0);
    end

    // Reset while full
    bus32.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 32'h90); step();
    drive(1'b1, 32'hFFF00093, 3'd0, 32'hA0); step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst2_valid",   64'(bus32.out_valid),   64'd0);
    chk("rst2_rdy",     64'(bus32.in_ready),    64'd1);
    chk("rst2_imm",     64'(bus32.out_imm_ext), 64'd0);
    chk("rst2_target",  64'(bus32.out_target),  64'd0);
    chk("rst2_pc",      64'(bus32.out_pc),      64'd0);
    chk("rst2_illegal", 64'(bus32.out_illegal), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
